// File: rtl/test_rand_delay_checking_sink_if.sv
// rtl/test_rand_delay_checking_sink_if.sv - val/rdy message stream between a source and the checking sink
interface test_rand_delay_checking_sink_if #(
  parameter int p_msg_sz = 1
);
  logic                val;
  logic                rdy;
  logic [p_msg_sz-1:0] msg;

  modport master (output val, output msg, input rdy);
  modport slave  (input val, input msg, output rdy);
endinterface

// File: rtl/test_rand_delay_checking_sink.sv
// rtl/test_rand_delay_checking_sink.sv - random back-pressure sink that checks each accepted message against a preloaded memory
module test_rand_delay_checking_sink #(
  parameter int          p_msg_sz    = 1,
  parameter int          p_mem_sz    = 1024,
  parameter int          p_idx_sz    = 11,
  parameter int          p_max_delay = 0,
  parameter logic [15:0] p_lfsr_seed = 16'hACE1
) (
  input  logic                           clk,
  input  logic                           reset,
  test_rand_delay_checking_sink_if.slave in_if,
  input  logic [p_idx_sz-1:0]            num_msgs,
  output logic                           done,
  output logic                           error,
  output logic [15:0]                    num_errors
);

  localparam int unsigned c_mod = p_max_delay + 1;
  localparam int          c_aw  = (p_mem_sz > 1) ? $clog2(p_mem_sz) : 1;

  typedef enum logic [1:0] {S_DELAY, S_READY, S_DONE} state_t;

  // Expected messages; written hierarchically by the harness, never reset.
  logic [p_msg_sz-1:0] m [p_mem_sz];

  state_t              state_q, state_d;
  logic [p_idx_sz-1:0] index_q, index_d;
  logic [15:0]         lfsr_q, lfsr_d;
  logic [15:0]         cnt_q, cnt_d;
  logic                error_q, error_d;
  logic [15:0]         num_errors_q, num_errors_d;

  logic [c_aw-1:0]     addr;
  logic [p_idx_sz-1:0] index_inc;
  logic [15:0]         lfsr_nxt;
  logic [15:0]         dly_nxt;
  logic                fire;

  function automatic logic [15:0] lfsr_step(logic [15:0] v);
    return {1'b0, v[15:1]} ^ (v[0] ? 16'hB400 : 16'h0000);
  endfunction

  function automatic logic [15:0] delay_of(logic [15:0] v);
    logic [31:0] r;
    r = {16'd0, v} % c_mod;
    return r[15:0];
  endfunction

  assign addr      = c_aw'(index_q);
  assign index_inc = index_q + {{(p_idx_sz-1){1'b0}}, 1'b1};
  assign lfsr_nxt  = lfsr_step(lfsr_q);
  assign dly_nxt   = delay_of(lfsr_nxt);
  assign fire      = in_if.val && (state_q == S_READY);

  always_comb begin
    state_d      = state_q;
    index_d      = index_q;
    lfsr_d       = lfsr_q;
    cnt_d        = cnt_q;
    error_d      = 1'b0;
    num_errors_d = num_errors_q;
    case (state_q)
      S_DELAY: begin
        if (num_msgs == '0) begin
          state_d = S_DONE;
        end else if (cnt_q == 16'd0) begin
          state_d = S_READY;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      S_READY: begin
        if (fire) begin
          // Case inequality so that X/Z on the bus counts as a mismatch.
          error_d = (in_if.msg !== m[addr]);
          if (error_d && (num_errors_q != 16'hFFFF)) begin
            num_errors_d = num_errors_q + 16'd1;
          end
          index_d = index_inc;
          lfsr_d  = lfsr_nxt;
          if (index_inc == num_msgs) begin
            state_d = S_DONE;
          end else if (dly_nxt != 16'd0) begin
            cnt_d   = dly_nxt - 16'd1;
            state_d = S_DELAY;
          end
        end
      end
      S_DONE: begin
        state_d = S_DONE;
      end
      default: begin
        state_d = S_DELAY;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_DELAY;
      index_q      <= '0;
      lfsr_q       <= p_lfsr_seed;
      cnt_q        <= delay_of(p_lfsr_seed);
      error_q      <= 1'b0;
      num_errors_q <= '0;
    end else begin
      state_q      <= state_d;
      index_q      <= index_d;
      lfsr_q       <= lfsr_d;
      cnt_q        <= cnt_d;
      error_q      <= error_d;
      num_errors_q <= num_errors_d;
    end
  end

  assign in_if.rdy  = (state_q == S_READY);
  assign done       = (state_q == S_DONE);
  assign error      = error_q;
  assign num_errors = num_errors_q;

endmodule

// File: tb/tb_test_rand_delay_checking_sink.sv
// tb/tb_test_rand_delay_checking_sink.sv - scoreboard bench for the random-delay checking sink
module tb_test_rand_delay_checking_sink;
  localparam int          W    = 8;
  localparam int          MEM  = 1024;
  localparam int          IW   = 11;
  localparam int          MAXD = 3;
  localparam logic [15:0] SEED = 16'hACE1;

  logic          clk   = 1'b0;
  logic          reset = 1'b1;
  logic [IW-1:0] num_msgs;
  logic          done;
  logic          error;
  logic [15:0]   num_errors;

  test_rand_delay_checking_sink_if #(.p_msg_sz(W)) bus ();

  test_rand_delay_checking_sink #(
    .p_msg_sz   (W),
    .p_mem_sz   (MEM),
    .p_idx_sz   (IW),
    .p_max_delay(MAXD),
    .p_lfsr_seed(SEED)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_if     (bus),
    .num_msgs  (num_msgs),
    .done      (done),
    .error     (error),
    .num_errors(num_errors)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  bit        exp_err_q[$];
  int        exp_stall_q[$];
  logic [W-1:0] exp_mem [64];
  logic [W-1:0] tx [64];

  task automatic check(string name, longint act, longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] model_next(logic [15:0] x);
    logic [15:0] r;
    r = x / 16'd2;
    if ((x % 16'd2) == 16'd1) r = r ^ 16'hB400;
    return r;
  endfunction

  function automatic int model_stall(logic [15:0] x);
    return int'(x) % (MAXD + 1);
  endfunction

  task automatic load_mem(int i, logic [W-1:0] v);
    exp_mem[i] = v;
    dut.m[10'(i)] = v;
  endtask

  // Called at posedge+1: holds reset low one cycle, then releases it.
  task automatic start_run(int nm);
    logic [15:0] l;
    reset = 1'b0;
    bus.val = 1'b0;
    bus.msg = '0;
    num_msgs = IW'(nm);
    exp_err_q.delete();
    exp_stall_q.delete();
    #1;
    check("reset_rdy", bus.rdy, 0);
    check("reset_done", done, 0);
    check("reset_error", error, 0);
    check("reset_num_errors", num_errors, 0);
    @(posedge clk);
    #1;
    if (nm > 0) begin
      l = SEED;
      exp_stall_q.push_back(model_stall(l) + 1);
      for (int k = 1; k < nm; k++) begin
        l = model_next(l);
        exp_stall_q.push_back(model_stall(l));
      end
    end
    reset = 1'b1;
  endtask

  task automatic send(logic [W-1:0] v, bit bad, int gap);
    bit f;
    int t;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    exp_err_q.push_back(bad);
    bus.val = 1'b1;
    bus.msg = v;
    t = 0;
    forever begin
      @(negedge clk);
      f = bus.rdy;
      @(posedge clk);
      #1;
      if (f) break;
      t++;
      if (t > 200) begin
        check("send_timeout", t, 0);
        break;
      end
    end
    bus.val = 1'b0;
  endtask

  task automatic finish_run(int nbad);
    int t;
    t = 0;
    while (!done && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("done_reached", done, 1);
    @(posedge clk);
    #1;
    check("final_num_errors", num_errors, nbad);
    check("stall_queue_drained", exp_stall_q.size(), 0);
    check("err_queue_drained", exp_err_q.size(), 0);
    bus.val = 1'b1;
    bus.msg = 8'hA5;
    repeat (3) begin
      @(negedge clk);
      check("rdy_low_in_done", bus.rdy, 0);
      check("done_held", done, 1);
    end
    @(posedge clk);
    #1;
    bus.val = 1'b0;
    check("num_errors_after_done", num_errors, nbad);
  endtask

  task automatic run(int nm, int gmax);
    int nbad;
    nbad = 0;
    start_run(nm);
    for (int i = 0; i < nm; i++) begin
      if (tx[i] != exp_mem[i]) nbad++;
      send(tx[i], tx[i] != exp_mem[i], (gmax == 0) ? 0 : int'($urandom_range(gmax, 0)));
    end
    finish_run(nbad);
  endtask

  // Monitor: stall lengths, error pulses, running error count, done timing.
  initial begin
    bit pend;
    bit waiting;
    bit fin;
    int scnt;
    int fires;
    int nerr;
    int es;
    bit eb;
    pend = 0; waiting = 0; fin = 1; scnt = 0; fires = 0; nerr = 0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        pend = 0; waiting = 1; scnt = 0; fires = 0; nerr = 0;
        fin = (num_msgs == '0);
        continue;
      end
      if (fin) continue;
      if (pend) begin
        pend = 0;
        if (exp_err_q.size() == 0) begin
          check("unexpected_fire", 1, 0);
        end else begin
          eb = exp_err_q.pop_front();
          if (eb) nerr++;
          check("error_pulse", error, eb);
          check("num_errors_running", num_errors, nerr);
        end
        fires++;
        if (fires == int'(num_msgs)) begin
          check("done_after_last_fire", done, 1);
          check("rdy_after_last_fire", bus.rdy, 0);
          fin = 1;
          continue;
        end
        check("done_early", done, 0);
        waiting = 1;
        scnt = 0;
      end else begin
        check("error_idle", error, 0);
      end
      if (waiting) begin
        if (bus.rdy) begin
          waiting = 0;
          if (exp_stall_q.size() == 0) begin
            check("unexpected_ready", 1, 0);
          end else begin
            es = exp_stall_q.pop_front();
            check("stall_len", scnt, es);
          end
        end else begin
          scnt++;
          if (scnt > 100) begin
            check("stall_timeout", scnt, 0);
            waiting = 0;
          end
        end
      end
      pend = bus.val && bus.rdy;
    end
  end

  initial begin
    bus.val = 1'b0;
    bus.msg = '0;
    num_msgs = '0;
    @(posedge clk);
    #1;

    // Four matching messages, no gaps.
    for (int i = 0; i < 4; i++) begin
      load_mem(i, W'(i + 1));
      tx[i] = W'(i + 1);
    end
    run(4, 0);

    // Middle message corrupted.
    load_mem(0, 8'h10); load_mem(1, 8'h20); load_mem(2, 8'h30);
    tx[0] = 8'h10; tx[1] = 8'h21; tx[2] = 8'h30;
    run(3, 0);

    // Eight random matching messages, LFSR stalls only.
    for (int i = 0; i < 8; i++) begin
      load_mem(i, W'($urandom));
      tx[i] = exp_mem[i];
    end
    run(8, 0);

    // Sixteen messages, random source gaps, about a quarter corrupted.
    for (int i = 0; i < 16; i++) begin
      load_mem(i, W'($urandom));
      tx[i] = exp_mem[i];
      if ($urandom_range(3, 0) == 0) tx[i] = exp_mem[i] ^ W'($urandom_range(255, 1));
    end
    run(16, 5);

    // Back-to-back corruptions.
    for (int i = 0; i < 6; i++) begin
      load_mem(i, W'($urandom));
      tx[i] = (i >= 2 && i <= 4) ? ~exp_mem[i] : exp_mem[i];
    end
    run(6, 1);

    // Reset after two of five messages, the second one bad.
    for (int i = 0; i < 5; i++) begin
      load_mem(i, W'($urandom));
      tx[i] = exp_mem[i];
    end
    start_run(5);
    send(exp_mem[0], 0, 0);
    send(~exp_mem[1], 1, 0);
    check("num_errors_before_reset", num_errors, 1);
    tx[3] = exp_mem[3] ^ 8'h01;
    run(5, 2);

    // No expected messages.
    start_run(0);
    @(negedge clk);
    check("nm0_done_before_edge", done, 0);
    @(posedge clk);
    #1;
    check("nm0_done", done, 1);
    check("nm0_rdy", bus.rdy, 0);
    bus.val = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("nm0_rdy_never", bus.rdy, 0);
      check("nm0_num_errors", num_errors, 0);
    end
    bus.val = 1'b0;

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=%0t expected=finish", $time);
    $fatal(1, "timeout");
  end

endmodule
